fp_add_pipe: RTL
================

Name: fp_add_pipe

Overview:
- Parametrised, pipelined IEEE-754-style floating-point adder/subtractor.
- Generalises the combinational single-precision adder:
  - configurable exponent and fraction widths
  - add/subtract mode
  - a fixed 3-stage register pipeline with valid/ready handshake
  - a user tag carried with each operation
  - exception flags
- Sits between operand producers and consumers in arithmetic datapaths and clears its pipeline on reset.

Parameters:
EXP_W, 8, exponent field width (>=3)
FRAC_W, 23, stored fraction width (>=2)
TAG_W, 4, width of user tag carried alongside each operation (>=1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  operand pair offered
in_ready  out  1  block can accept operands this cycle
in_x  in  1+EXP_W+FRAC_W  operand x {sign, exp, frac}
in_y  in  1+EXP_W+FRAC_W  operand y
in_sub  in  1  1: compute x-y (y sign inverted before add); 0: x+y
in_tag  in  TAG_W  user tag
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_z  out  1+EXP_W+FRAC_W  result
out_tag  out  TAG_W  tag of this result
out_invalid  out  1  result is NaN (operand NaN or inf-inf)
out_overflow  out  1  finite operands produced infinity by exponent overflow

Behaviour:
- Reset (async, active-high): all stage valid bits cleared; out_valid=0, out_z=0, out_tag=0, out_invalid=0, out_overflow=0. Reset mid-operation discards in-flight results; none appear after reset release.
- Pipeline enable:
  - en = !out_valid || out_ready.
  - in_ready = en.
  - When en=1, every stage shifts one step.
  - A transfer occurs when in_valid && in_ready; otherwise a bubble (valid=0) enters.
- Stalls: when en=0 all stages hold; out_z, out_tag and flags stay stable while out_valid && !out_ready.
- Latency: 3 cycles. A result is visible on out_valid exactly 3 en-cycles after acceptance. Throughput is 1 per cycle with out_ready held high. Results emerge in acceptance order.
- Stage 1 (align):
  - Apply in_sub to y's sign.
  - Swap so the larger biased exponent is operand A (tie: x is A).
  - Operands with exp==0 have their fraction treated as 0 (subnormal inputs flush to zero).
  - Build wide fractions {01, frac, 000} of FRAC_W+5 bits.
  - Right-shift B by the exponent difference; shifts >= FRAC_W+5 give 0.
  - Any bit shifted out ORs into the LSB (sticky).
- Stage 2 (add/normalise):
  - Add or subtract by effective sign; negative difference is negated and the sign noted.
  - Leading-zero count; carry-out shifts right 1 with sticky OR, otherwise normalise by shifting left.
- Stage 3 (round/pack):
  - Round to nearest, ties to even, using 3 guard bits. Round up when low3 > 100b, or low3 == 100b and kept LSB = 1.
  - Rounding carry increments the exponent.
  - Biased exponent result <= 0: output signed zero, frac 0 (subnormal output flush).
  - Exponent >= all-ones: infinity (exp all-ones, frac 0), out_overflow=1 when no operand was inf/NaN.
- Zero result sign: exact zero sum gives sign = signA & signB, so -0 results only when both effective signs are negative.
- Specials, in priority order:
  - Any NaN operand, or +inf with -inf (after in_sub): out_z = {0, all-ones, 1 followed by zeros} (quiet NaN), out_invalid=1.
  - Otherwise any infinite operand: infinity with that operand's sign.
- Flags are 0 whenever not asserted by the rules above. out_tag equals the in_tag accepted with that operation.

Test Plan:
- Defaults, out_ready=1, back-to-back 0x3F800000+0x3F800000, then 0x40400000+0xBF800000 -> 0x40000000 then 0x40000000 on consecutive cycles, 3 cycles after each accept; tags preserved.
- in_sub=1, 0x3F800000 and 0x3F800000 -> 0x00000000. Adding 0x80000000+0x80000000 -> 0x80000000.
- Rounding: 0x3F800000+0x33800000 -> 0x3F800000; 0x3F800001+0x33800000 -> 0x3F800002. Subnormal 0x00000001+0x00000000 -> 0x00000000.
- Specials:
  - 0x7F800000+0xFF800000 -> 0x7FC00000, invalid=1.
  - 0x7F7FFFFF+0x7F7FFFFF -> 0x7F800000, overflow=1.
  - 0xFF800000+0x3F800000 -> 0xFF800000, flags 0.
- Backpressure: issue 5 ops, hold out_ready=0 for 6 cycles -> in_ready drops once out_valid=1; out_z held stable; all 5 results delivered in order after release, none lost or duplicated.
- Assert rst with 3 ops in flight -> out_valid=0 immediately (asynchronously). After release, no stale result appears; the next op completes in 3 cycles.

Source files
------------

// File: rtl/fp_add_pipe.sv
// fp_add_pipe: parametrised three-stage floating-point adder/subtractor
// with valid/ready flow control, user tag and exception flags.
module fp_add_pipe #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int TAG_W  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [EXP_W+FRAC_W:0]     in_x,
    input  logic [EXP_W+FRAC_W:0]     in_y,
    input  logic                      in_sub,
    input  logic [TAG_W-1:0]          in_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+FRAC_W:0]     out_z,
    output logic [TAG_W-1:0]          out_tag,
    output logic                      out_invalid,
    output logic                      out_overflow
);

    localparam int W   = 1 + EXP_W + FRAC_W;
    localparam int WF  = FRAC_W + 5;
    localparam int LZW = $clog2(WF) + 1;
    localparam int EW  = ((EXP_W > LZW) ? EXP_W : LZW) + 2;
    localparam logic [EXP_W-1:0] EMAX = '1;

    logic en;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // ---------------- stage 1: unpack, classify, swap, align
    logic               x_s, y_s, a_s, b_s;
    logic [EXP_W-1:0]   x_e, y_e, a_e, b_e, d;
    logic [FRAC_W-1:0]  x_f, y_f;
    logic [WF-1:0]      x_m, y_m, a_m, b_m, lost, b_al;
    logic               x_nan, y_nan, x_inf, y_inf, swap;
    logic               nan1, inf1, infs1;

    assign x_s = in_x[W-1];
    assign x_e = in_x[W-2:FRAC_W];
    assign x_f = in_x[FRAC_W-1:0];
    assign y_s = in_y[W-1] ^ in_sub;
    assign y_e = in_y[W-2:FRAC_W];
    assign y_f = in_y[FRAC_W-1:0];

    assign x_nan = (x_e == EMAX) && (x_f != '0);
    assign y_nan = (y_e == EMAX) && (y_f != '0);
    assign x_inf = (x_e == EMAX) && (x_f == '0);
    assign y_inf = (y_e == EMAX) && (y_f == '0);

    // subnormal operands are flushed: no hidden bit, no fraction
    assign x_m = (x_e == '0) ? '0 : {2'b01, x_f, 3'b000};
    assign y_m = (y_e == '0) ? '0 : {2'b01, y_f, 3'b000};

    assign swap = y_e > x_e;
    assign a_s  = swap ? y_s : x_s;
    assign b_s  = swap ? x_s : y_s;
    assign a_e  = swap ? y_e : x_e;
    assign b_e  = swap ? x_e : y_e;
    assign a_m  = swap ? y_m : x_m;
    assign b_m  = swap ? x_m : y_m;

    assign d    = a_e - b_e;
    assign lost = b_m & ~({WF{1'b1}} << d);
    assign b_al = (b_m >> d) | {{(WF-1){1'b0}}, |lost};

    assign nan1  = x_nan | y_nan | (x_inf & y_inf & (x_s ^ y_s));
    assign inf1  = x_inf | y_inf;
    assign infs1 = x_inf ? x_s : y_s;

    logic               s1_v, s1_sa, s1_sb, s1_nan, s1_inf, s1_is;
    logic [EXP_W-1:0]   s1_e;
    logic [WF-1:0]      s1_ma, s1_mb;
    logic [TAG_W-1:0]   s1_tag;

    // capture aligned operands and special-case summary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v   <= 1'b0;
            s1_sa  <= 1'b0;
            s1_sb  <= 1'b0;
            s1_nan <= 1'b0;
            s1_inf <= 1'b0;
            s1_is  <= 1'b0;
            s1_e   <= '0;
            s1_ma  <= '0;
            s1_mb  <= '0;
            s1_tag <= '0;
        end else if (en) begin
            s1_v   <= in_valid;
            s1_sa  <= a_s;
            s1_sb  <= b_s;
            s1_nan <= nan1;
            s1_inf <= inf1;
            s1_is  <= infs1;
            s1_e   <= a_e;
            s1_ma  <= a_m;
            s1_mb  <= b_al;
            s1_tag <= in_tag;
        end
    end

    // ---------------- stage 2: add/subtract and normalise
    logic               eff_sub, rs;
    logic [WF-1:0]      sum;
    logic [WF-2:0]      norm;
    logic [LZW-1:0]     lz;
    logic               found;
    logic signed [EW-1:0] ne;

    // magnitude add/sub, leading-zero count and normalising shift
    always_comb begin
        eff_sub = s1_sa ^ s1_sb;
        rs      = s1_sa;
        sum     = '0;
        if (!eff_sub) begin
            sum = s1_ma + s1_mb;
        end else if (s1_ma >= s1_mb) begin
            sum = s1_ma - s1_mb;
        end else begin
            sum = s1_mb - s1_ma;
            rs  = s1_sb;
        end
        if (sum == '0)
            rs = s1_sa & s1_sb;

        lz    = '0;
        found = 1'b0;
        for (int i = WF - 2; i >= 0; i--) begin
            if (!found) begin
                if (sum[i])
                    found = 1'b1;
                else
                    lz = lz + LZW'(1);
            end
        end

        if (sum[WF-1]) begin
            norm = {sum[WF-1:2], sum[1] | sum[0]};
            ne   = EW'(s1_e) + EW'(1);
        end else begin
            norm = sum[WF-2:0] << lz;
            ne   = EW'(s1_e) - EW'(lz);
        end
    end

    logic               s2_v, s2_s, s2_nan, s2_inf, s2_is;
    logic signed [EW-1:0] s2_e;
    logic [WF-2:0]      s2_m;
    logic [TAG_W-1:0]   s2_tag;

    // capture normalised mantissa with unbounded exponent
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_v   <= 1'b0;
            s2_s   <= 1'b0;
            s2_nan <= 1'b0;
            s2_inf <= 1'b0;
            s2_is  <= 1'b0;
            s2_e   <= '0;
            s2_m   <= '0;
            s2_tag <= '0;
        end else if (en) begin
            s2_v   <= s1_v;
            s2_s   <= rs;
            s2_nan <= s1_nan;
            s2_inf <= s1_inf;
            s2_is  <= s1_is;
            s2_e   <= ne;
            s2_m   <= norm;
            s2_tag <= s1_tag;
        end
    end

    // ---------------- stage 3: round and pack
    logic [FRAC_W:0]    kept, mant_r;
    logic [2:0]         low3;
    logic               rup;
    logic [FRAC_W+1:0]  rnd;
    logic signed [EW-1:0] er;
    logic [W-1:0]       z3;
    logic               inv3, ovf3;

    // nearest-even rounding, then range and special-value selection
    always_comb begin
        kept   = s2_m[WF-2:3];
        low3   = s2_m[2:0];
        rup    = (low3 > 3'd4) || ((low3 == 3'd4) && kept[0]);
        rnd    = {1'b0, kept} + (FRAC_W+2)'(rup);
        mant_r = rnd[FRAC_W+1] ? rnd[FRAC_W+1:1] : rnd[FRAC_W:0];
        er     = s2_e + EW'(rnd[FRAC_W+1]);
        inv3   = 1'b0;
        ovf3   = 1'b0;
        z3     = {s2_s, er[EXP_W-1:0], mant_r[FRAC_W-1:0]};
        if (s2_nan) begin
            z3   = {1'b0, EMAX, 1'b1, {(FRAC_W-1){1'b0}}};
            inv3 = 1'b1;
        end else if (s2_inf) begin
            z3 = {s2_is, EMAX, {FRAC_W{1'b0}}};
        end else if (!mant_r[FRAC_W] || er[EW-1] || (er == '0)) begin
            z3 = {s2_s, {(EXP_W+FRAC_W){1'b0}}};
        end else if (er >= EW'(EMAX)) begin
            z3   = {s2_s, EMAX, {FRAC_W{1'b0}}};
            ovf3 = 1'b1;
        end
    end

    // output register, held while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_z        <= '0;
            out_tag      <= '0;
            out_invalid  <= 1'b0;
            out_overflow <= 1'b0;
        end else if (en) begin
            out_valid    <= s2_v;
            out_z        <= z3;
            out_tag      <= s2_tag;
            out_invalid  <= inv3;
            out_overflow <= ovf3;
        end
    end

endmodule
